// File: rtl/nibbler_sequencer.sv
// nibbler_sequencer: instruction sequencer for the Nibbler 4-bit CPU.
// Owns the program counter, instruction/operand registers and carry/zero flags,
// fetches instruction bytes from program ROM and drives the control strobes of
// the accumulator, ALU, data memory and output port.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   run        fetch enable, sampled in FETCH
//   rom_data   program ROM byte at address pc (combinational)
//   alu_carry  ALU carry-out for the current operation
//   alu_zero   ALU result-is-zero for the current operation
//   pc         program counter / ROM address
//   data_addr  data memory address {ir[3:0], opnd}
//   imm        immediate field ir[3:0]
//   a_load     accumulator load enable
//   alu_op     ALU function (00 pass B, 01 A+B, 10 NAND, 11 pass A)
//   b_sel      ALU B source (00 imm, 01 data memory, 10 input port)
//   mem_we     data memory write strobe
//   out_load   output port load strobe
//   carry_flag registered carry flag
//   zero_flag  registered zero flag
//   halted     high while in HALT
module nibbler_sequencer #(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  rom_data,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic [11:0] pc,
  output logic [11:0] data_addr,
  output logic [3:0]  imm,
  output logic        a_load,
  output logic [1:0]  alu_op,
  output logic [1:0]  b_sel,
  output logic        mem_we,
  output logic        out_load,
  output logic        carry_flag,
  output logic        zero_flag,
  output logic        halted
);

  typedef enum logic [1:0] {StFetch, StFetchOp, StExec, StHalt} state_e;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  opnd_q, opnd_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        jump;

  // Opcodes 4..E carry an operand byte.
  function automatic logic is_two_byte(input logic [3:0] op);
    return (op >= 4'h4) && (op != 4'hF);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= PC_RESET;
      ir_q    <= 8'h00;
      opnd_q  <= 8'h00;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Strobes depend only on state_q and ir_q, so they never glitch with rom_data.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    opnd_d   = opnd_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    a_load   = 1'b0;
    alu_op   = 2'b00;
    b_sel    = 2'b00;
    mem_we   = 1'b0;
    out_load = 1'b0;
    jump     = 1'b0;

    case (state_q)
      StFetch: begin
        if (run) begin
          ir_d    = rom_data;
          pc_d    = pc_q + 12'd1;
          state_d = is_two_byte(rom_data[7:4]) ? StFetchOp : StExec;
        end
      end
      StFetchOp: begin
        opnd_d  = rom_data;
        pc_d    = pc_q + 12'd1;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        case (ir_q[7:4])
          4'h1: a_load = 1'b1;
          4'h2: begin a_load = 1'b1; alu_op = 2'b01; end
          4'h3: begin a_load = 1'b1; alu_op = 2'b10; end
          4'h4: begin a_load = 1'b1; alu_op = 2'b01; b_sel = 2'b01; end
          4'h5: begin a_load = 1'b1; alu_op = 2'b10; b_sel = 2'b01; end
          4'h6: begin a_load = 1'b1; b_sel = 2'b01; end
          4'h7: mem_we = 1'b1;
          4'h8: out_load = 1'b1;
          4'h9: begin a_load = 1'b1; b_sel = 2'b10; end
          4'hA: jump = 1'b1;
          4'hB: jump = carry_q;
          4'hC: jump = ~carry_q;
          4'hD: jump = zero_q;
          4'hE: jump = ~zero_q;
          4'hF: state_d = StHalt;
          default: ;
        endcase
        // Untaken jumps leave pc pointing at the next instruction.
        if (jump) pc_d = {ir_q[3:0], opnd_q};
        if (a_load) begin
          carry_d = alu_carry;
          zero_d  = alu_zero;
        end
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  assign pc         = pc_q;
  assign data_addr  = {ir_q[3:0], opnd_q};
  assign imm        = ir_q[3:0];
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Self-checking bench for nibbler_sequencer: directed scenarios followed by a
// random program run against an instruction-level reference interpreter.
module tb_nibbler_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        alu_carry = 1'b0;
  logic        alu_zero = 1'b0;
  logic [7:0]  rom_data;
  logic [11:0] pc, data_addr;
  logic [3:0]  imm;
  logic        a_load, mem_we, out_load, carry_flag, zero_flag, halted;
  logic [1:0]  alu_op, b_sel;

  logic        reset2 = 1'b1;
  logic        run2 = 1'b0;
  logic [7:0]  rom_data2;
  logic [11:0] pc2, data_addr2;
  logic [3:0]  imm2;
  logic        a_load2, mem_we2, out_load2, carry_flag2, zero_flag2, halted2;
  logic [1:0]  alu_op2, b_sel2;

  logic [7:0]  rom [4096];
  logic [6:0]  ctl, ctl2;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [11:0] m_pc;
  logic        m_c, m_z;
  logic [11:0] exec_addr;
  logic [6:0]  exec_ctl;

  assign rom_data  = rom[pc];
  assign rom_data2 = rom[pc2];
  assign ctl  = {a_load, alu_op, b_sel, mem_we, out_load};
  assign ctl2 = {a_load2, alu_op2, b_sel2, mem_we2, out_load2};

  always #5 clk = ~clk;

  nibbler_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .rom_data(rom_data),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .pc(pc), .data_addr(data_addr),
    .imm(imm), .a_load(a_load), .alu_op(alu_op), .b_sel(b_sel), .mem_we(mem_we),
    .out_load(out_load), .carry_flag(carry_flag), .zero_flag(zero_flag), .halted(halted)
  );

  nibbler_sequencer #(.PC_RESET(12'hFFF)) dut2 (
    .clk(clk), .reset(reset2), .run(run2), .rom_data(rom_data2),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .pc(pc2), .data_addr(data_addr2),
    .imm(imm2), .a_load(a_load2), .alu_op(alu_op2), .b_sel(b_sel2), .mem_we(mem_we2),
    .out_load(out_load2), .carry_flag(carry_flag2), .zero_flag(zero_flag2),
    .halted(halted2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Opcode table: {a_load, alu_op, b_sel, mem_we, out_load} during EXEC.
  function automatic logic [6:0] exp_ctl(input logic [3:0] op);
    case (op)
      4'h1: return 7'b1_00_00_0_0;
      4'h2: return 7'b1_01_00_0_0;
      4'h3: return 7'b1_10_00_0_0;
      4'h4: return 7'b1_01_01_0_0;
      4'h5: return 7'b1_10_01_0_0;
      4'h6: return 7'b1_00_01_0_0;
      4'h7: return 7'b0_00_00_1_0;
      4'h8: return 7'b0_00_00_0_1;
      4'h9: return 7'b1_00_10_0_0;
      default: return 7'b0;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc = 12'h000;
    m_c  = 1'b0;
    m_z  = 1'b0;
  endtask

  // Executes one non-HLT instruction at m_pc, checking every cycle.
  task automatic run_instr(input bit rnd_alu, input logic c, input logic z);
    logic [7:0] b0, b1;
    logic [3:0] op;
    bit two, take;
    b0  = rom[m_pc];
    op  = b0[7:4];
    two = (op >= 4'h4) && (op != 4'hF);
    b1  = 8'h00;
    chk("fetch_pc", pc, m_pc);
    chk("fetch_ctl", ctl, 7'b0);
    chk("fetch_halted", halted, 1'b0);
    step();
    m_pc = m_pc + 12'd1;
    if (two) begin
      chk("fop_pc", pc, m_pc);
      chk("fop_ctl", ctl, 7'b0);
      b1   = rom[m_pc];
      m_pc = m_pc + 12'd1;
      step();
    end
    chk("exec_pc", pc, m_pc);
    chk("exec_ctl", ctl, exp_ctl(op));
    chk("exec_imm", imm, b0[3:0]);
    if (two) chk("exec_addr", data_addr, {b0[3:0], b1});
    exec_addr = data_addr;
    exec_ctl  = ctl;
    if (rnd_alu) begin
      alu_carry = 1'($urandom);
      alu_zero  = 1'($urandom);
    end else begin
      alu_carry = c;
      alu_zero  = z;
    end
    step();
    case (op)
      4'hA: take = 1'b1;
      4'hB: take = m_c;
      4'hC: take = !m_c;
      4'hD: take = m_z;
      4'hE: take = !m_z;
      default: take = 1'b0;
    endcase
    if (take) m_pc = {b0[3:0], b1};
    if (exp_ctl(op)[6]) begin
      m_c = alu_carry;
      m_z = alu_zero;
    end
    chk("flags", {carry_flag, zero_flag}, {m_c, m_z});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;

    // Reset state.
    do_reset();
    chk("rst_pc", pc, 12'h000);
    chk("rst_ctl", ctl, 7'b0);
    chk("rst_imm", imm, 4'h0);
    chk("rst_addr", data_addr, 12'h000);
    chk("rst_flags", {carry_flag, zero_flag, halted}, 3'b000);

    // run=0 holds.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_pc", pc, 12'h000);
      chk("hold_ctl", ctl, 7'b0);
    end

    // LIT.
    rom[0] = 8'h15;
    do_reset();
    run = 1'b1;
    step();
    chk("lit_ctl", ctl, 7'b1_00_00_0_0);
    chk("lit_imm", imm, 4'h5);
    step();
    chk("lit_pc", pc, 12'h001);

    // JMP.
    rom[0] = 8'hA3; rom[1] = 8'hA7;
    do_reset();
    run_instr(1'b1, 1'b0, 1'b0);
    chk("jmp_pc", pc, 12'h3A7);

    // JC not taken.
    rom[0] = 8'hB1; rom[1] = 8'h00;
    do_reset();
    run_instr(1'b1, 1'b0, 1'b0);
    chk("jc_nt_pc", pc, 12'h002);

    // JC taken after ADDI sets carry.
    rom[0] = 8'h21; rom[1] = 8'hB1; rom[2] = 8'h00;
    do_reset();
    run_instr(1'b0, 1'b1, 1'b0);
    chk("addi_carry", carry_flag, 1'b1);
    run_instr(1'b1, 1'b0, 1'b0);
    chk("jc_t_pc", pc, 12'h100);

    // ST.
    rom[0] = 8'h72; rom[1] = 8'h34; rom[2] = 8'h00;
    do_reset();
    run_instr(1'b1, 1'b0, 1'b0);
    chk("st_addr", exec_addr, 12'h234);
    chk("st_ctl", exec_ctl, 7'b0_00_00_1_0);
    chk("st_after_ctl", ctl, 7'b0);

    // HLT.
    rom[0] = 8'hF0;
    do_reset();
    step();
    chk("hlt_exec_ctl", ctl, 7'b0);
    chk("hlt_exec_halted", halted, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      chk("halt_halted", halted, 1'b1);
      chk("halt_pc", pc, 12'h001);
      chk("halt_ctl", ctl, 7'b0);
      step();
    end
    do_reset();
    chk("halt_cleared", halted, 1'b0);

    // pc wrap in FETCH (PC_RESET=FFF, NOP at FFF).
    rom[12'hFFF] = 8'h00;
    reset2 = 1'b0;
    run2   = 1'b1;
    chk("wrap_start_pc", pc2, 12'hFFF);
    step();
    chk("wrap_exec_pc", pc2, 12'h000);
    chk("wrap_exec_ctl", ctl2, 7'b0);
    run2 = 1'b0;
    step();
    chk("wrap_fetch_pc", pc2, 12'h000);

    // pc wrap in FETCH_OP: jump to FFF, LD there takes its operand from 000.
    rom[0] = 8'hAF; rom[1] = 8'hFF; rom[12'hFFF] = 8'h60;
    do_reset();
    run_instr(1'b1, 1'b0, 1'b0);
    chk("wrap_jmp_pc", pc, 12'hFFF);
    run_instr(1'b1, 1'b0, 1'b0);
    chk("wrap_op_pc", pc, 12'h001);
    chk("wrap_op_addr", exec_addr, 12'h0AF);
    rom[12'hFFF] = 8'h00;

    // run falls mid-instruction: ADDM completes, then stall in FETCH.
    rom[0] = 8'h40; rom[1] = 8'h12;
    do_reset();
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    chk("rundrop_exec_ctl", ctl, 7'b1_01_01_0_0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("rundrop_pc", pc, 12'h002);
      chk("rundrop_ctl", ctl, 7'b0);
      step();
    end

    // Reset asserted mid-EXEC of ADDI.
    rom[0] = 8'h2F;
    do_reset();
    run = 1'b1;
    alu_carry = 1'b1;
    alu_zero  = 1'b1;
    step();
    chk("mid_exec_ctl", ctl, 7'b1_01_00_0_0);
    #1 reset = 1'b1;
    #1 chk("mid_rst_ctl", ctl, 7'b0);
    chk("mid_rst_pc", pc, 12'h000);
    @(posedge clk);
    #1;
    chk("mid_rst_flags", {carry_flag, zero_flag}, 2'b00);
    reset = 1'b0;
    m_pc = 12'h000; m_c = 1'b0; m_z = 1'b0;
    run_instr(1'b1, 1'b0, 1'b0);

    // Random programs against the instruction-level model (HLT remapped to NOP).
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 8'($urandom);
      if (rom[i][7:4] == 4'hF) rom[i] = {4'h0, rom[i][3:0]};
    end
    do_reset();
    run = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) begin
        run = 1'b0;
        for (int s = 0; s < int'($urandom_range(3, 1)); s++) begin
          step();
          chk("stall_pc", pc, m_pc);
          chk("stall_ctl", ctl, 7'b0);
        end
        run = 1'b1;
      end
      run_instr(1'b1, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
